// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if
//   Request/result bundle between a requesting block and serial_add_ctrl.
//   master : drives start, a, b; observes busy, done, sum, cout
//   slave  : the adder controller
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// ha
//   Half adder: s = x ^ y, c = x & y.
module ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

// serial_add_ctrl
//   Bit-serial adder controller. It adds two WIDTH-bit operands one bit per
//   clock, LSB first, through a single full-adder cell that is built from two
//   ha instances.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : synchronous reset, active-low
//     bus   : slave side of serial_add_ctrl_if
//             start/a/b in, busy/done/sum/cout out
//   sum/cout are updated only when the last bit is produced, so partial
//   results never reach the outputs.
//
//   state | meaning
//   IDLE  | waiting for start; a/b captured on the accepting edge
//   RUN   | one operand bit pair added per edge, WIDTH edges in total
//   FIN   | done pulse for one cycle; start ignored
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_add_ctrl_if.slave    bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opb_q, res_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic             s0, c0, s1, c1, fa_c;
  logic             last_bit;
  logic [WIDTH:0]   res_shift;
  logic [WIDTH-1:0] res_next;

  // full adder = two half adders plus an OR of their carries
  ha u_ha0 (.x(opa_q[0]), .y(opb_q[0]), .s(s0), .c(c0));
  ha u_ha1 (.x(s0),       .y(carry_q),  .s(s1), .c(c1));
  assign fa_c = c0 | c1;

  // new bit enters at the MSB; the widened shift keeps WIDTH=1 legal
  assign res_shift = {s1, res_q} >> 1;
  assign res_next  = res_shift[WIDTH-1:0];
  assign last_bit  = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_bit)  state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            opa_q   <= bus.a;
            opb_q   <= bus.b;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          opa_q   <= opa_q >> 1;
          opb_q   <= opb_q >> 1;
          res_q   <= res_next;
          carry_q <= fa_c;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            sum_q  <= res_next;
            cout_q <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == FIN);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  // reference: last completed result visible on sum/cout
  logic [WIDTH-1:0] ref_sum  = '0;
  logic             ref_cout = 1'b0;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic bsy, input logic dn);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
    chk({tag, ".done"}, 32'(bus.done), 32'(dn));
    chk({tag, ".sum"},  32'(bus.sum),  32'(ref_sum));
    chk({tag, ".cout"}, 32'(bus.cout), 32'(ref_cout));
  endtask

  // One full operation: accept, WIDTH busy cycles, one done cycle, back to IDLE.
  // noisy: hammer start and a/b while busy and in FIN.
  // keep : leave start high after the operation for back-to-back issue.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] ta,
                        input logic [WIDTH-1:0] tb_v, input bit noisy, input bit keep);
    logic [WIDTH:0] full;
    full = {1'b0, ta} + {1'b0, tb_v};
    bus.a = ta;
    bus.b = tb_v;
    bus.start = 1'b1;
    tick();
    if (!keep) bus.start = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      chk_out({tag, ".run"}, 1'b1, 1'b0);
      if (noisy) begin
        bus.start = 1'(i % 2 == 0);
        bus.a = (i == 0) ? '1 : WIDTH'($urandom);
        bus.b = (i == 0) ? '1 : WIDTH'($urandom);
      end
      tick();
    end
    ref_sum  = full[WIDTH-1:0];
    ref_cout = full[WIDTH];
    chk_out({tag, ".fin"}, 1'b0, 1'b1);
    if (noisy) bus.start = 1'b1;
    tick();
    chk_out({tag, ".idle"}, 1'b0, 1'b0);
    if (!keep) bus.start = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;

    // 1. reset held with start high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("reset", 1'b0, 1'b0);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk_out("post_reset", 1'b0, 1'b0);

    // 2. basic add and latency
    run_op("basic", 8'h03, 8'h05, 1'b0, 1'b0);
    tick();
    chk_out("basic_hold", 1'b0, 1'b0);

    // 3. carry chain
    run_op("carry1", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("carry2", 8'hFF, 8'hFF, 1'b0, 1'b0);

    // 4. ignored requests while busy and in FIN
    run_op("ignore", 8'h10, 8'h20, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("ignore_quiet", 1'b0, 1'b0);
    end

    // 5. back-to-back with start held: acceptance every WIDTH+2 cycles
    for (int k = 0; k < 3; k++)
      run_op("b2b", 8'h80, 8'h80, 1'b0, 1'b1);
    bus.start = 1'b0;
    tick();
    chk_out("b2b_end", 1'b0, 1'b0);

    // 6. reset in the 4th RUN cycle
    bus.a = 8'h7F;
    bus.b = 8'h01;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_out("abort_run", 1'b1, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ref_sum  = '0;
    ref_cout = 1'b0;
    chk_out("abort_reset", 1'b0, 1'b0);
    for (int i = 0; i < WIDTH + 2; i++) begin
      tick();
      chk_out("abort_nodone", 1'b0, 1'b0);
    end
    run_op("after_abort", 8'h7F, 8'h01, 1'b0, 1'b0);

    // randomized operations against the arithmetic model
    for (int k = 0; k < 8; k++)
      run_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'(k % 2), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller that sequences a single half-adder-based full-adder cell to add two WIDTH-bit operands, one bit per clock, LSB first. It accepts a request with a start/busy/done handshake and shifts operands through the shared adder cell. It manages the carry register and collects the result, which it holds stable until the next accepted request. It sits between a requesting block and the shared `ha` datapath. The internal full adder is exactly two `ha` instances plus an OR of their carries.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1 to 32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepting edge
b  input  WIDTH  operand B; captured on the accepting edge
busy  output  1  high while the operation is in progress (state RUN)
done  output  1  single-cycle pulse; sum/cout newly valid
sum  output  WIDTH  registered result, a+b modulo 2^WIDTH
cout  output  1  registered carry-out of the WIDTH-bit addition

Behaviour:
- Reset: any rising edge with rst_n=0 forces the following, regardless of state:
  - state=IDLE, busy=0, done=0, sum=0, cout=0;
  - internal shift registers, carry register and bit counter cleared.
  - start is ignored on that edge.
- States: IDLE, RUN, FIN (2-bit encoding). Bit counter width is clog2(WIDTH+1).
- IDLE: busy=0, done=0.
  - Edge with start=1 (call it E0): load a and b into operand shift registers, carry reg=0, counter=0, go to RUN.
  - start=0: stay in IDLE.
- RUN: busy=1, done=0. Each edge:
  - s = opA[0]^opB[0]^carry and c = majority(opA[0], opB[0], carry), computed via the two `ha` instances.
  - s shifts into the MSB of the result shift register (right shift).
  - opA and opB shift right; carry<=c; counter++.
  - On the edge where counter==WIDTH-1 (edge E_WIDTH): load sum<=final result shift value and cout<=c, then go to FIN.
- FIN: busy=0, done=1 for exactly one cycle. The next edge goes to IDLE. start is ignored in FIN.
- Latency:
  - busy is high for exactly WIDTH cycles after E0.
  - done is high in the cycle following edge E0+WIDTH.
  - The earliest next acceptance is edge E0+WIDTH+2.
- sum/cout change only on the RUN->FIN edge or on reset. They hold the last result through IDLE and through the entire next RUN. Partial results are never visible on the outputs.
- start while busy or in FIN: ignored, with no queuing.
- a/b changes after E0 have no effect on the running operation.
- Holding start=1 continuously: a new operation is accepted at every IDLE edge, giving a period of WIDTH+2 cycles.
- Reset mid-RUN: the operation is aborted and sum/cout read 0. No done pulse is produced.
- WIDTH=1: RUN lasts one cycle; the transition to FIN happens on the first RUN edge.
- Arithmetic: unsigned. The {cout,sum} result equals a+b exactly as a WIDTH+1-bit value.

Test Plan:
1. Reset and defaults:
   - Stimulus: hold rst_n=0 for 3 edges with start=1, a=8'hAA, b=8'h55.
   - Required response: busy=0, done=0, sum=8'h00, cout=0 throughout. No operation starts on release unless start is still high in IDLE.
2. Basic add and latency (WIDTH=8):
   - Stimulus: a=8'h03, b=8'h05, start pulsed at E0.
   - Required response: busy high for exactly 8 cycles; done high only after E8; sum=8'h08, cout=0; both hold after done drops.
3. Carry chain:
   - Stimulus: 8'hFF+8'h01, then 8'hFF+8'hFF.
   - Required response: sum=8'h00, cout=1; then sum=8'hFE, cout=1. Previous result stays stable during the second RUN.
4. Ignored requests:
   - Stimulus: accept 8'h10+8'h20. While busy, pulse start with a=8'hFF, b=8'hFF and change a/b every cycle; pulse start again during FIN.
   - Required response: a single done pulse with sum=8'h30, cout=0, and no second operation.
5. Back-to-back:
   - Stimulus: start held at 1 with a=8'h80, b=8'h80.
   - Required response: acceptance every 10 cycles; each done gives sum=8'h00, cout=1.
6. Reset mid-operation:
   - Stimulus: rst_n=0 for one edge at the 4th RUN cycle of 8'h7F+8'h01.
   - Required response: busy=0 and sum=0 on the next cycle; no done pulse. A following 8'h7F+8'h01 completes with sum=8'h80, cout=0.
